seg7_decimal: RTL and testbench

SEG7_DECIMAL -- requirements
Module: seg7_decimal

---
 rtl/seg7_decimal.sv | 192 +++++++++++++++++++
 tb/tb_seg7_decimal.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_decimal.sv
// seg7_decimal
// Drives a 4-digit, common-anode seven-segment display with the decimal
// representation of a 16-bit unsigned value. The value is registered,
// converted to BCD with a shift-and-add-3 (double-dabble) network, and the
// BCD result is registered. A free-running refresh counter then multiplexes
// the four digits onto one shared segment bus.
//
// Display rules:
//   - Values above 9999 show a dash on every digit.
//   - Leading zeros are blanked. The ones digit is always lit, so zero
//     appears as a single "0".
//
// The segment bus and the digit enables come from the same register stage.
// Each segment pattern is therefore always paired with its own digit, and
// no glitch appears when the scan moves to the next digit.

module seg7_decimal #(
    parameter int REFRESH_BITS = 20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] data,
    output logic [7:0]  a_to_g,
    output logic [3:0]  an,
    output logic        dp
);

    // Segment patterns for a_to_g[6:0], active-low, bit6 = a ... bit0 = g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h7E;

    localparam logic [REFRESH_BITS-1:0] COUNT_ONE = 1;

    // Refresh counter; its top two bits select the digit being driven.
    logic [REFRESH_BITS-1:0] counter_q;
    logic [REFRESH_BITS-1:0] counter_d;
    logic [1:0]              digit_sel;

    // Input register.
    logic [15:0] data_q;
    logic [15:0] data_d;

    // Raw double-dabble result: five BCD digits, ten-thousands in [19:16].
    logic [19:0] bcd_raw;

    // Registered BCD digits plus the out-of-range flag.
    logic [3:0] ones_q;
    logic [3:0] tens_q;
    logic [3:0] hundreds_q;
    logic [3:0] thousands_q;
    logic       over_q;
    logic [3:0] ones_d;
    logic [3:0] tens_d;
    logic [3:0] hundreds_d;
    logic [3:0] thousands_d;
    logic       over_d;

    // Output registers.
    logic [3:0] an_q;
    logic [3:0] an_d;
    logic [7:0] seg_q;
    logic [7:0] seg_d;

    // Per-digit selection used to build the next output pattern.
    logic [3:0] cur_digit;
    logic       cur_show;
    logic [6:0] cur_seg;

    // Maps one BCD digit to its active-low segment pattern.
    function automatic logic [6:0] encode_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h01;
            4'd1:    seg = 7'h4F;
            4'd2:    seg = 7'h12;
            4'd3:    seg = 7'h06;
            4'd4:    seg = 7'h4C;
            4'd5:    seg = 7'h24;
            4'd6:    seg = 7'h20;
            4'd7:    seg = 7'h0F;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h04;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // The counter runs freely and wraps. The input is sampled every cycle.
    always_comb begin
        counter_d = counter_q + COUNT_ONE;
        data_d    = data;
    end

    assign digit_sel = counter_q[REFRESH_BITS-1 -: 2];

    // Double-dabble: before each shift, any BCD digit of 5 or more gets 3
    // added, so that the following shift carries correctly into the next
    // decimal digit.
    always_comb begin
        bcd_raw = '0;
        for (int i = 15; i >= 0; i--) begin
            for (int k = 0; k < 5; k++) begin
                if (bcd_raw[4*k +: 4] >= 4'd5) begin
                    bcd_raw[4*k +: 4] = bcd_raw[4*k +: 4] + 4'd3;
                end
            end
            bcd_raw = {bcd_raw[18:0], data_q[i]};
        end
    end

    // Splits the BCD result into the digit registers' next values. A
    // non-zero ten-thousands digit means the value exceeds 9999.
    always_comb begin
        ones_d      = bcd_raw[3:0];
        tens_d      = bcd_raw[7:4];
        hundreds_d  = bcd_raw[11:8];
        thousands_d = bcd_raw[15:12];
        over_d      = (bcd_raw[19:16] != 4'd0);
    end

    // Picks the digit to drive next, and applies dashing and leading-zero blanking.
    always_comb begin
        cur_digit = ones_q;
        cur_show  = 1'b1;
        an_d      = 4'b1110;
        case (digit_sel)
            2'd0: begin
                cur_digit = ones_q;
                cur_show  = 1'b1;
                an_d      = 4'b1110;
            end
            2'd1: begin
                cur_digit = tens_q;
                cur_show  = (tens_q != 4'd0) || (hundreds_q != 4'd0) ||
                            (thousands_q != 4'd0);
                an_d      = 4'b1101;
            end
            2'd2: begin
                cur_digit = hundreds_q;
                cur_show  = (hundreds_q != 4'd0) || (thousands_q != 4'd0);
                an_d      = 4'b1011;
            end
            default: begin
                cur_digit = thousands_q;
                cur_show  = (thousands_q != 4'd0);
                an_d      = 4'b0111;
            end
        endcase

        if (over_q) begin
            cur_seg = SEG_DASH;
        end else if (cur_show) begin
            cur_seg = encode_digit(cur_digit);
        end else begin
            cur_seg = SEG_BLANK;
        end

        seg_d = {1'b1, cur_seg};
    end

    // Registers the refresh counter, the input value, the BCD digits and the
    // display outputs. Reset blanks the display at once and rewinds the scan
    // to the ones digit.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            counter_q   <= '0;
            data_q      <= '0;
            ones_q      <= '0;
            tens_q      <= '0;
            hundreds_q  <= '0;
            thousands_q <= '0;
            over_q      <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 8'hFF;
        end else begin
            counter_q   <= counter_d;
            data_q      <= data_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            hundreds_q  <= hundreds_d;
            thousands_q <= thousands_d;
            over_q      <= over_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an     = an_q;
    assign a_to_g = seg_q;
    assign dp     = 1'b1;

endmodule

// File: tb/tb_seg7_decimal.sv
// Directed testbench for seg7_decimal with a short refresh counter
// (REFRESH_BITS = 4), so each digit is held for 4 clocks.

module tb_seg7_decimal;

    logic        clk;
    logic        clr;
    logic [15:0] data;
    logic [7:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;

    int checks;
    int errors;

    seg7_decimal #(
        .REFRESH_BITS(4)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .data  (data),
        .a_to_g(a_to_g),
        .an    (an),
        .dp    (dp)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset holds the display dark, and the first edge after release
    // enables the ones digit. The scan then steps every 4 clocks.
    task automatic test_reset();
        logic [3:0] exp_an [4];
        exp_an = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        clr  = 1'b0;
        data = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL reset_an got=%b expected=%b", an, 4'b1111);
        end
        checks++;
        if (a_to_g !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_seg got=%h expected=%h", a_to_g, 8'hFF);
        end
        checks++;
        if (dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_dp got=%b expected=1", dp);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL first_edge_an got=%b expected=%b", an, 4'b1110);
        end
        checks++;
        if (a_to_g !== 8'h81) begin
            errors++;
            $display("[TB] FAIL first_edge_seg got=%h expected=%h", a_to_g, 8'h81);
        end
        for (int s = 0; s < 4; s++) begin
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (an !== exp_an[s]) begin
                errors++;
                $display("[TB] FAIL scan_order step=%0d got=%b expected=%b", s, an, exp_an[s]);
            end
        end
    endtask

    // Several values with every digit position exercised, including
    // zeros inside a number, which must remain visible.
    task automatic test_multi_digit();
        logic [15:0] vals [3];
        logic [7:0]  exp_tab [3][4];
        int          pos;
        vals    = '{16'd1234, 16'd100, 16'd1005};
        exp_tab = '{'{8'hCC, 8'h86, 8'h92, 8'hCF},
                    '{8'h81, 8'h81, 8'hCF, 8'hFF},
                    '{8'hA4, 8'h81, 8'h81, 8'hCF}};
        for (int v = 0; v < 3; v++) begin
            data = vals[v];
            repeat (20) @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                case (an)
                    4'b1110: pos = 0;
                    4'b1101: pos = 1;
                    4'b1011: pos = 2;
                    4'b0111: pos = 3;
                    default: pos = -1;
                endcase
                checks++;
                if (pos < 0) begin
                    errors++;
                    $display("[TB] FAIL multi_digit_an value=%0d got=%b expected one low bit", vals[v], an);
                end else if (a_to_g !== exp_tab[v][pos]) begin
                    errors++;
                    $display("[TB] FAIL multi_digit value=%0d an=%b got=%h expected=%h",
                             vals[v], an, a_to_g, exp_tab[v][pos]);
                end
            end
        end
    endtask

    // Leading zeros are blanked, but the ones digit is always shown.
    task automatic test_blanking();
        logic [15:0] vals [3];
        logic [7:0]  exp_tab [3][4];
        int          pos;
        vals    = '{16'd7, 16'd0, 16'd40};
        exp_tab = '{'{8'h8F, 8'hFF, 8'hFF, 8'hFF},
                    '{8'h81, 8'hFF, 8'hFF, 8'hFF},
                    '{8'h81, 8'hCC, 8'hFF, 8'hFF}};
        for (int v = 0; v < 3; v++) begin
            data = vals[v];
            repeat (20) @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                case (an)
                    4'b1110: pos = 0;
                    4'b1101: pos = 1;
                    4'b1011: pos = 2;
                    4'b0111: pos = 3;
                    default: pos = -1;
                endcase
                checks++;
                if (pos < 0) begin
                    errors++;
                    $display("[TB] FAIL blanking_an value=%0d got=%b expected one low bit", vals[v], an);
                end else if (a_to_g !== exp_tab[v][pos]) begin
                    errors++;
                    $display("[TB] FAIL blanking value=%0d an=%b got=%h expected=%h",
                             vals[v], an, a_to_g, exp_tab[v][pos]);
                end
            end
        end
    endtask

    // Values above 9999 show dashes on every digit. 9999 itself still shows digits.
    task automatic test_overflow();
        logic [15:0] vals [3];
        logic [7:0]  exp_seg [3];
        vals    = '{16'd10000, 16'd9999, 16'd65535};
        exp_seg = '{8'hFE, 8'h84, 8'hFE};
        for (int v = 0; v < 3; v++) begin
            data = vals[v];
            repeat (20) @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                checks++;
                if (an != 4'b1110 && an != 4'b1101 && an != 4'b1011 && an != 4'b0111) begin
                    errors++;
                    $display("[TB] FAIL overflow_an value=%0d got=%b expected one low bit", vals[v], an);
                end else if (a_to_g !== exp_seg[v]) begin
                    errors++;
                    $display("[TB] FAIL overflow value=%0d an=%b got=%h expected=%h",
                             vals[v], an, a_to_g, exp_seg[v]);
                end
            end
        end
    endtask

    // Changes the value at the start of the ones window. The value passes
    // through three register stages (input, BCD, output), so the ones digit
    // changes within the same window. The scan does not restart.
    task automatic test_mid_scan_change();
        bit found;
        data = 16'd25;
        repeat (20) @(negedge clk);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (an == 4'b0111) found = 1'b1;
        end
        if (found) begin
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                if (an == 4'b1110) found = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL mid_change_sync got an=%b expected=%b within 40 clocks", an, 4'b1110);
        end else begin
            checks++;
            if (a_to_g !== 8'hA4) begin
                errors++;
                $display("[TB] FAIL mid_change_old got=%h expected=%h", a_to_g, 8'hA4);
            end
            data = 16'd30;
            @(negedge clk);
            checks++;
            if (an !== 4'b1110) begin
                errors++;
                $display("[TB] FAIL mid_change_no_restart got=%b expected=%b", an, 4'b1110);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (an !== 4'b1110 || a_to_g !== 8'h81) begin
                errors++;
                $display("[TB] FAIL mid_change_ones got an=%b seg=%h expected an=1110 seg=81", an, a_to_g);
            end
            @(negedge clk);
            checks++;
            if (an !== 4'b1101 || a_to_g !== 8'h86) begin
                errors++;
                $display("[TB] FAIL mid_change_tens got an=%b seg=%h expected an=1101 seg=86", an, a_to_g);
            end
        end
    endtask

    // Reset asserted between clock edges blanks the display at once. After
    // release, the scan begins again at the ones digit.
    task automatic test_mid_scan_reset();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (an == 4'b1011) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL mid_reset_sync got an=%b expected=%b within 40 clocks", an, 4'b1011);
        end
        #2;
        clr = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || a_to_g !== 8'hFF || dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_async got an=%b seg=%h dp=%b expected an=1111 seg=FF dp=1",
                     an, a_to_g, dp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL mid_reset_hold got=%b expected=%b", an, 4'b1111);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL mid_reset_restart got=%b expected=%b", an, 4'b1110);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL mid_reset_ones_hold got=%b expected=%b", an, 4'b1110);
        end
        @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL mid_reset_next got=%b expected=%b", an, 4'b1101);
        end
    endtask

    // Runs every scenario in sequence, then reports.
    initial begin
        checks = 0;
        errors = 0;
        clr    = 1'b0;
        data   = 16'd0;
        $display("[TB] starting seg7_decimal tests");
        test_reset();
        test_multi_digit();
        test_blanking();
        test_overflow();
        test_mid_scan_change();
        test_mid_scan_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
